// File: rtl/hex_frame_sender_pkg.sv
// hex_frame_sender_pkg: ASCII constants and FSM state encoding shared by the frame sender
//   no ports; imported by hex_nibble_ascii and hex_frame_sender
package hex_frame_sender_pkg;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  typedef enum logic [2:0] {ST_IDLE, ST_DIGIT, ST_SEP, ST_CR, ST_LF} state_t;
endpackage

// File: rtl/hex_frame_sender_if.sv
// hex_frame_sender_if: valid/ready byte stream towards the UART transmitter
//   data  8-bit ASCII byte, valid  byte present, ready  sink accepts
//   master drives data/valid, slave drives ready
interface hex_frame_sender_if;
  logic [7:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/hex_nibble_ascii.sv
// hex_nibble_ascii: combinational map of a 4-bit value to its upper-case ASCII hex digit
//   nibble  in  4-bit value
//   ascii   out 8'h30..8'h39 for 0..9, 8'h41..8'h46 for 10..15
module hex_nibble_ascii
  import hex_frame_sender_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  assign ascii = (nibble < 4'd10) ? ASCII_ZERO + {4'h0, nibble} : ASCII_UA + {4'h0, nibble} - 8'd10;
endmodule

// File: rtl/hex_frame_sender.sv
// hex_frame_sender: serialises a snapshot of NUM_FIELDS fields as an ASCII hex text frame
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   frame request, sampled only while idle
//   data   in   fields, field 0 in the MS slice, captured on accepted start
//   busy   out  high from the cycle after an accepted start until done
//   done   out  one-cycle pulse after the final byte transfers
//   tx     master byte stream (data/valid out, ready in)
module hex_frame_sender
  import hex_frame_sender_pkg::*;
#(
  parameter int         NUM_FIELDS  = 2,
  parameter int         FIELD_WIDTH = 16,
  parameter logic [7:0] SEP_CHAR    = ASCII_COMMA,
  parameter bit         TERM_CR     = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] data,
  output logic                              busy,
  output logic                              done,
  hex_frame_sender_if.master                tx
);
  localparam int TOT    = NUM_FIELDS * FIELD_WIDTH;
  localparam int DIGITS = FIELD_WIDTH / 4;
  localparam int NW     = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int FW     = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam logic [NW-1:0] NLAST = NW'(DIGITS - 1);
  localparam logic [FW-1:0] FLAST = FW'(NUM_FIELDS - 1);
  state_t state, state_n;
  logic [TOT-1:0] shadow, shadow_n, src;
  logic [NW-1:0] nib, nib_n;
  logic [FW-1:0] fld, fld_n;
  logic [3:0] nibble;
  logic [7:0] digit, data_n;
  logic valid_n, busy_n, done_n, xfer;
  assign xfer = tx.valid & tx.ready;
  // The digit is looked up for the position being presented next; on start
  // the shadow is not loaded yet, so the first digit comes straight from data.
  assign src = (state == ST_IDLE) ? data : shadow;
  assign nibble = 4'(src >> (TOT - 4 - int'(fld_n) * FIELD_WIDTH - int'(nib_n) * 4));
  hex_nibble_ascii u_nib (.nibble(nibble), .ascii(digit));
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    nib_n    = nib;
    fld_n    = fld;
    valid_n  = tx.valid;
    busy_n   = busy;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        shadow_n = data;
        state_n  = ST_DIGIT;
        nib_n    = '0;
        fld_n    = '0;
        valid_n  = 1'b1;
        busy_n   = 1'b1;
      end
      ST_DIGIT: if (xfer) begin
        if (nib == NLAST) begin
          nib_n = '0;
          if (fld == FLAST) begin
            fld_n   = '0;
            state_n = TERM_CR ? ST_CR : ST_LF;
          end else state_n = ST_SEP;
        end else nib_n = nib + NW'(1);
      end
      ST_SEP: if (xfer) begin
        state_n = ST_DIGIT;
        fld_n   = fld + FW'(1);
      end
      ST_CR: if (xfer) state_n = ST_LF;
      ST_LF: if (xfer) begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    // While stalled, state and indices are unchanged so the byte recomputes to itself.
    data_n = (state_n == ST_DIGIT) ? digit :
             (state_n == ST_SEP)   ? SEP_CHAR :
             (state_n == ST_CR)    ? ASCII_CR :
             (state_n == ST_LF)    ? ASCII_LF : tx.data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shadow   <= '0;
      nib      <= '0;
      fld      <= '0;
      tx.data  <= 8'h00;
      tx.valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      nib      <= nib_n;
      fld      <= fld_n;
      tx.data  <= data_n;
      tx.valid <= valid_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end
endmodule

// File: tb/tb_hex_frame_sender.sv
// tb_hex_frame_sender: directed checks of the hex frame sender, default and single-field builds
module tb_hex_frame_sender;
  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0, rdy = 1'b0;
  logic [31:0] data0 = '0;
  logic [15:0] data1 = '0;
  logic busy0, done0, busy1, done1;
  int checks = 0, errors = 0;
  logic [7:0] f1 [11] = '{8'h31, 8'h32, 8'h41, 8'h42, 8'h2C, 8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] f2 [11] = '{8'h39, 8'h41, 8'h46, 8'h30, 8'h2C, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] f6a [11] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] f6b [11] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  hex_frame_sender_if tx0 ();
  hex_frame_sender_if tx1 ();
  assign tx0.ready = rdy;
  assign tx1.ready = rdy;
  always #5 clk = ~clk;
  hex_frame_sender u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .data(data0),
    .busy(busy0), .done(done0), .tx(tx0)
  );
  hex_frame_sender #(.NUM_FIELDS(1), .FIELD_WIDTH(16), .SEP_CHAR(8'h2C), .TERM_CR(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data(data1),
    .busy(busy1), .done(done1), .tx(tx1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Called at the negedge where the first byte should already be valid.
  // mode 0: ready always high; 1: stall 5 cycles at byte 3 then random ready;
  // 2: ready high plus a spurious start and data change mid-frame.
  task automatic frame(input int d, input int len, input logic [7:0] exp [11], input int mode);
    int idx = 0, cyc = 0, stall = 0;
    logic v, b, dn;
    logic [7:0] dt;
    while (idx < len && cyc < 200) begin
      v  = d ? tx1.valid : tx0.valid;
      b  = d ? busy1 : busy0;
      dt = d ? tx1.data : tx0.data;
      chk($sformatf("valid[%0d]", idx), {31'b0, v}, 1);
      chk($sformatf("busy[%0d]", idx), {31'b0, b}, 1);
      chk($sformatf("byte[%0d]", idx), {24'b0, dt}, {24'b0, exp[idx]});
      if (mode == 1) begin
        if (idx == 3 && stall < 5) begin
          rdy = 1'b0;
          stall++;
        end else rdy = 1'($urandom_range(0, 1));
      end else rdy = 1'b1;
      if (mode == 2) begin
        start0 = (cyc == 3);
        if (cyc == 3) data0 = 32'hFFFF_FFFF;
      end
      if (rdy && v) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("frame_len", idx, len);
    if (mode != 1) chk("frame_cycles", cyc, len);
    rdy = 1'b1;
    v  = d ? tx1.valid : tx0.valid;
    b  = d ? busy1 : busy0;
    dn = d ? done1 : done0;
    chk("done_pulse", {31'b0, dn}, 1);
    chk("end_valid", {31'b0, v}, 0);
    chk("end_busy", {31'b0, b}, 0);
  endtask
  initial begin
    #12;
    chk("rst_data", {24'b0, tx0.data}, 0);
    chk("rst_valid", {31'b0, tx0.valid}, 0);
    chk("rst_busy", {31'b0, busy0}, 0);
    chk("rst_done", {31'b0, done0}, 0);
    chk("rst_valid1", {31'b0, tx1.valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_valid", {31'b0, tx0.valid}, 0);
    data0 = 32'h12AB_00FF;
    start0 = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    frame(0, 11, f1, 0);
    @(negedge clk);
    chk("done_single1", {31'b0, done0}, 0);
    data0 = 32'h9AF0_0000;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    frame(0, 11, f2, 0);
    @(negedge clk);
    data0 = 32'h12AB_00FF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    frame(0, 11, f1, 1);
    @(negedge clk);
    data0 = 32'h12AB_00FF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    frame(0, 11, f1, 2);
    @(negedge clk);
    chk("t4_done_once", {31'b0, done0}, 0);
    chk("t4_no_queue_valid", {31'b0, tx0.valid}, 0);
    chk("t4_no_queue_busy", {31'b0, busy0}, 0);
    @(negedge clk);
    chk("t4_still_idle", {31'b0, tx0.valid}, 0);
    data0 = 32'h12AB_00FF;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_byte4", {24'b0, tx0.data}, 32'h2C);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'b0, tx0.valid}, 0);
    chk("t5_rst_busy", {31'b0, busy0}, 0);
    chk("t5_rst_data", {24'b0, tx0.data}, 0);
    chk("t5_rst_done", {31'b0, done0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    frame(0, 11, f1, 0);
    @(negedge clk);
    data1 = 16'hABCD;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    frame(1, 5, f6a, 0);
    data1 = 16'h0123;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    frame(1, 5, f6b, 0);
    @(negedge clk);
    chk("t6_done_once", {31'b0, done1}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
